// File: rtl/pc_sequencer_pkg.sv
// Shared widths and FSM encoding for the fetch-stage program-counter sequencer.
package pc_seq_pkg;

   localparam int PC_W      = 10;
   localparam int LUT_AW    = 4;
   localparam int CW        = 16;
   localparam int LUT_DEPTH = 2 ** LUT_AW;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Decoder/config/fetch-side signal bundle of the PC sequencer.
interface pc_sequencer_if;
   import pc_seq_pkg::*;

   logic              start;
   logic              stall;
   logic              halt_req;
   logic              branch_en;
   logic              branch_abs;
   logic [LUT_AW-1:0] lut_idx;
   logic              cfg_we;
   logic [LUT_AW-1:0] cfg_addr;
   logic [PC_W-1:0]   cfg_data;
   logic [PC_W-1:0]   prog_ctr;
   logic              fetch_valid;
   logic              done;
   logic              cfg_err;
   logic [CW-1:0]     instr_cnt;

   modport master (
      output start, stall, halt_req, branch_en, branch_abs, lut_idx,
             cfg_we, cfg_addr, cfg_data,
      input  prog_ctr, fetch_valid, done, cfg_err, instr_cnt
   );

   modport slave (
      input  start, stall, halt_req, branch_en, branch_abs, lut_idx,
             cfg_we, cfg_addr, cfg_data,
      output prog_ctr, fetch_valid, done, cfg_err, instr_cnt
   );

endinterface

// File: rtl/pc_sequencer_target_lut.sv
// Branch-target register file: synchronous write and clear, combinational read.
module target_lut #(
   parameter int AW = 4,
   parameter int DW = 10
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < 2**AW; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC controller: IDLE/RUN/DONE sequencing, table-resolved branches,
// saturating retired-instruction counter.
module pc_sequencer
   import pc_seq_pkg::*;
(
   input  logic           Clk,
   input  logic           Reset,
   pc_sequencer_if.slave  bus
);

   localparam logic [1:0] S_IDLE = IDLE;
   localparam logic [1:0] S_RUN  = RUN;
   localparam logic [1:0] S_DONE = DONE;

   logic [1:0]      state;
   logic [PC_W-1:0] pc;
   logic [CW-1:0]   cnt;
   logic            cfg_err_r;
   logic [PC_W-1:0] target;
   logic [PC_W-1:0] next_pc;
   logic            cfg_write;

   // The table is frozen while running so a branch never races a reload.
   assign cfg_write = bus.cfg_we && (state != S_RUN);

   target_lut #(
      .AW (LUT_AW),
      .DW (PC_W)
   ) u_lut (
      .Clk   (Clk),
      .Reset (Reset),
      .we    (cfg_write),
      .waddr (bus.cfg_addr),
      .wdata (bus.cfg_data),
      .raddr (bus.lut_idx),
      .rdata (target)
   );

   // Relative targets are two's complement; dropping the carry gives the wrap.
   always_comb begin
      next_pc = pc + PC_W'(1);
      if (bus.branch_en) begin
         next_pc = bus.branch_abs ? target : (pc + target);
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state     <= S_IDLE;
         pc        <= '0;
         cnt       <= '0;
         cfg_err_r <= 1'b0;
      end else begin
         cfg_err_r <= bus.cfg_we && (state == S_RUN);
         case (state)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  state <= S_RUN;
                  pc    <= '0;
                  cnt   <= '0;
               end
            end
            S_RUN: begin
               if (!bus.stall) begin
                  if (bus.halt_req) begin
                     state <= S_DONE;
                  end else begin
                     pc <= next_pc;
                     if (cnt != {CW{1'b1}}) begin
                        cnt <= cnt + CW'(1);
                     end
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.prog_ctr    = pc;
   assign bus.instr_cnt   = cnt;
   assign bus.done        = (state == S_DONE);
   assign bus.cfg_err     = cfg_err_r;
   assign bus.fetch_valid = (state == S_RUN) && !bus.stall;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter controller for the fetch stage. It sequences the PC through idle, run and done, and resolves taken branches through an internal writable 16-entry branch-target table. The table is loaded through a configuration port while the core is not running. Branches are either absolute (PC = entry) or PC-relative (PC = PC + entry, with the entry treated as two's complement). Sits between the instruction decoder (halt/branch strobes) and instruction memory (PC address).

Parameters:
D, 10, PC width in bits; all PC arithmetic is modulo 2**D
LUT_AW, 4, branch-target table index width (table depth 2**LUT_AW = 16)
CW, 16, width of the retired-instruction counter

Ports:
Clk  input  1  system clock; all state updates on the rising edge
Reset  input  1  synchronous, active-high reset
start  input  1  begin execution from PC 0; honoured in IDLE or DONE only
stall  input  1  hold PC and counter this cycle; RUN only
halt_req  input  1  decoded halt instruction at the current PC
branch_en  input  1  taken branch at the current PC
branch_abs  input  1  1 = absolute target, 0 = PC-relative offset
lut_idx  input  LUT_AW  branch-target table index for branch_en
cfg_we  input  1  table write strobe
cfg_addr  input  LUT_AW  table write index
cfg_data  input  D  table write data
prog_ctr  output  D  current PC, registered
fetch_valid  output  1  prog_ctr is a valid fetch address this cycle
done  output  1  level; high in DONE
cfg_err  output  1  one-cycle pulse: write rejected because state is RUN
instr_cnt  output  CW  count of PC advances since last start, saturating

Behaviour:
- Reset (synchronous, highest priority): state=IDLE, prog_ctr=0, instr_cnt=0, done=0, fetch_valid=0, cfg_err=0, all 16 table entries=0.
- States: IDLE -> RUN on start. RUN -> DONE on halt_req with stall=0. DONE -> RUN on start. No other transitions; start in RUN is ignored.
- On entry to RUN: prog_ctr=0 and instr_cnt=0 on that edge.
- fetch_valid is combinational: (state==RUN) && !stall. done is registered: (state==DONE).
- Per-cycle priority in RUN, applied at the next edge:
  - stall: everything holds; halt_req and branch_en are ignored.
  - halt_req: go to DONE, PC holds, counter holds.
  - branch_en: abs gives PC=lut[lut_idx]; rel gives PC=(PC+lut[lut_idx]) mod 2**D. Counter increments.
  - otherwise: PC=(PC+1) mod 2**D. Counter increments.
- Wrap-around: PC 2**D-1 +1 gives 0. Relative add discards the carry (e.g. 4 + 0x3FF gives 3).
- instr_cnt saturates at 2**CW-1; it never wraps.
- PC and instr_cnt hold in DONE and IDLE.
- Table writes:
  - Accepted in IDLE or DONE: entry updated at the edge, readable from the next cycle.
  - In RUN: write dropped, cfg_err=1 for exactly the next cycle.
  - Write coincident with start in IDLE/DONE: the write is accepted.
- Reads are combinational from the registered table. A branch in the cycle after a write sees the new value.
- Reset asserted mid-RUN: returns to IDLE next edge with all values above; table contents are lost.
- Latency: prog_ctr reflects a control decision one clock after it is sampled.

Decomposition:
- Package pc_seq_pkg: state enum (IDLE, RUN, DONE), localparams PC_W=10, LUT_AW=4, CW=16.
- Sub-module target_lut: 2**LUT_AW x D register file; synchronous write with write enable, asynchronous read, synchronous clear on Reset. The sequencer FSM, PC adder and counter stay in pc_sequencer.

Test Plan:
1. Reset, then start with no other inputs for 5 cycles -> prog_ctr 0,1,2,3,4,5; fetch_valid=1; instr_cnt=5.
2. In IDLE write lut[1]=9 and start; at PC=2 assert branch_en with branch_abs=1, lut_idx=1 -> next prog_ctr=9; instr_cnt increments.
3. Write lut[2]=0x3FB (-5); at PC=20 assert a relative branch on idx 2 -> prog_ctr=15. Write lut[3]=0x3FF; at PC=4 take a relative branch on idx 3 -> prog_ctr=3.
4. At PC=7 assert stall, halt_req and branch_en together -> PC stays 7, state stays RUN. Next cycle halt_req alone -> done=1 and PC=7; start then gives PC=0 and done=0.
5. In RUN, cfg_we to idx 1 with data 5 -> cfg_err pulses for one cycle; a later absolute branch on idx 1 still gives 9.
6. Force the PC to 0x3FF (absolute branch to an entry of 0x3FF) and run 1 more cycle -> PC=0. Assert Reset mid-run -> IDLE, PC=0, and an absolute branch on idx 1 after restart gives 0.
